// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester, round-robin arbitrated 32-bit add/subtract unit.
//
// Each requester offers an operation (a, b, cin, sub) with a valid/ready handshake.
// The winner's operands go through a single ripple-carry adder. The result comes back
// on a shared response bus, with a per-requester valid/ready handshake.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   reqN_valid / reqN_ready      request handshake, requester N (N = 0, 1)
//   reqN_a, reqN_b               32-bit operands
//   reqN_cin, reqN_sub           carry-in (add only) and subtract select
//   rspN_valid / rspN_ready      response handshake, requester N
//   rsp_sum, rsp_cout, rsp_ovf   shared result: sum, carry-out, signed overflow
//   busy                         high whenever an operation is in flight

// 32-bit ripple-carry adder.
module rca (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [32:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 32; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[32];

endmodule

module adder_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_sub,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;    // requester served most recently
  logic        owner_q, owner_d;  // requester owning the in-flight operation
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;          // effective B (already inverted for subtract)
  logic        cin_q, cin_d;      // effective carry-in
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic        grant;
  logic        xfer;
  logic        sel_sub;
  logic [31:0] sel_b;
  logic        sel_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  rca u_rca (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // On a tie, favour the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
  end

  // Ready is gated by rst so that nothing is accepted while reset is held.
  assign req0_ready = (state_q == StIdle) && !rst && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && !rst && req1_valid && grant;
  assign xfer       = req0_ready || req1_ready;

  assign sel_sub = grant ? req1_sub : req0_sub;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_cin = grant ? req1_cin : req0_cin;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          owner_d = grant;
          a_d     = grant ? req1_a : req0_a;
          b_d     = sel_sub ? ~sel_b : sel_b;
          cin_d   = sel_sub ? 1'b1 : sel_cin;
          state_d = StCalc;
        end
      end
      StCalc: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        ovf_d   = (a_q[31] == b_q[31]) && (add_sum[31] != a_q[31]);
        state_d = StResp;
      end
      StResp: begin
        // Only the owner's ready retires the response.
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp0_valid = (state_q == StResp) && !owner_q;
  assign rsp1_valid = (state_q == StResp) && owner_q;
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 No parameters; datapath SHALL be fixed at 32 bits, built around one instance of the team's 32-bit ripple-carry adder (rca).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  requester N's operation accepted this cycle.
REQ-007 reqN_a  input  32  operand A, requester N.
REQ-008 reqN_b  input  32  operand B, requester N.
REQ-009 reqN_cin  input  1  carry-in, requester N (ignored when reqN_sub=1).
REQ-010 reqN_sub  input  1  1 = subtract (A-B), 0 = add (A+B+cin).
REQ-011 rspN_valid  output  1  result for requester N available.
REQ-012 rspN_ready  input  1  requester N takes the result.
REQ-013 rsp_sum  output  32  shared result bus, valid with either rspN_valid.
REQ-014 rsp_cout  output  1  adder carry-out.
REQ-015 rsp_ovf  output  1  signed two's-complement overflow.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have three states: IDLE, CALC, RESP.
REQ-018 IDLE: at most one reqN_ready high, combinationally, only for the granted requester with reqN_valid=1; transfer = valid & ready.
REQ-019 Arbitration SHALL be round-robin: one requester valid -> grant it; both valid -> grant the one not served last; last-served pointer initialises to 1 so requester 0 wins the first tie.
REQ-020 On transfer: latch a, effective b, effective cin, owner id; IDLE -> CALC.
REQ-021 Effective operands: sub=0 -> b, cin; sub=1 -> ~b, cin forced to 1.
REQ-022 CALC (exactly one cycle): adder driven from latched operands; sum, cout, ovf registered at cycle end; CALC -> RESP.
REQ-023 ovf = (a[31] == b_eff[31]) & (sum[31] != a[31]).
REQ-024 RESP: rspN_valid high for owner only; rsp_sum/cout/ovf held stable until rspN_ready=1 at a clock edge; then RESP -> IDLE and last-served pointer := owner.
REQ-025 Latency: transfer edge to owner rspN_valid = 2 cycles; minimum issue interval 3 cycles (no new accept in CALC or RESP).
REQ-026 Both reqN_ready SHALL be 0 in CALC and RESP; a non-granted requester keeps valid asserted and is served next.
REQ-027 rspN_ready while not owner or not in RESP SHALL be ignored.
REQ-028 Wrap-around: sums are modulo 2^32; carry beyond bit 31 appears only on rsp_cout.
REQ-029 Request inputs SHALL not be sampled outside the transfer cycle.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, last-served=1, all reqN_ready=0 while rst high, rspN_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0.
REQ-031 Reset during CALC or RESP SHALL discard the in-flight operation; no response is issued after reset release.
REQ-032 First transfer possible on the first rising edge after rst deasserts.

Verification
REQ-033 Req0 only: a=0x0000_0005, b=0x0000_0003, cin=1, sub=0 -> 2 cycles later rsp0_valid, sum=0x0000_0009, cout=0, ovf=0.
REQ-034 Both valid same cycle after reset (req0 7+1, req1 10-4 sub) -> req0 served first (sum=0x8), then req1 (sum=0x6, cout=1), req1 ready never high while busy.
REQ-035 Overflow/wrap: a=0x7FFF_FFFF+b=0x1 -> sum=0x8000_0000, ovf=1, cout=0; a=0xFFFF_FFFF+b=0x1 -> sum=0, cout=1, ovf=0.
REQ-036 Backpressure: hold rsp1_ready=0 for 5 cycles in RESP -> rsp1_valid and rsp_sum stable, busy=1, req0_ready=0 throughout; accept on 6th.
REQ-037 Fairness: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-038 Assert rst for 1 cycle during CALC -> all outputs zero, no rspN_valid afterwards; next request completes normally.
